// File: rtl/f_pc_unit.sv
// Fetch-stage program counter: next-PC selection, exception/eret redirects,
// delay-slot tracking, fetch address-error detection and a fetch counter.
module f_pc_unit #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6ffc,
  parameter int unsigned N_STALL  = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_STALL-1:0] stall,
  input  logic              jump,
  input  logic              jr,
  input  logic              branch,
  input  logic              cmp,
  input  logic [ADDR_W-1:0] ra,
  input  logic [25:0]       imm26,
  input  logic              req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc,
  output logic              f_bd,
  output logic              d_bd,
  output logic              f_adel,
  output logic [CNT_W-1:0]  fetch_cnt
);

  localparam logic [ADDR_W-1:0] RESET_A = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] EXC_A   = EXC_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LO_A    = IMEM_LO[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] HI_A    = IMEM_HI[ADDR_W-1:0];
  localparam int unsigned       SEXT_W  = ADDR_W - 18;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              d_bd_q, d_bd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              stall_any;
  logic              ctrl;
  logic              advance;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] jump_tgt;

  always_comb begin
    stall_any = |stall;
    ctrl      = jump | jr | branch;
    advance   = req | ~stall_any;
    pc_plus4  = pc_q + ADDR_W'(4);
    br_off    = {{SEXT_W{imm26[15]}}, imm26[15:0], 2'b00};
    jump_tgt  = {pc_q[ADDR_W-1:28], imm26, 2'b00};
  end

  // Exception flush outranks stall; eret carries no delay slot.
  always_comb begin
    pc_d = pc_plus4;
    if (req)                  pc_d = EXC_A;
    else if (stall_any)       pc_d = pc_q;
    else if (eret)            pc_d = epc;
    else if (jump)            pc_d = jump_tgt;
    else if (jr)              pc_d = ra;
    else if (branch && cmp)   pc_d = pc_q + br_off;
    else                      pc_d = pc_plus4;
  end

  always_comb begin
    d_bd_d = f_bd;
    if (req)            d_bd_d = 1'b0;
    else if (stall_any) d_bd_d = d_bd_q;
    else if (eret)      d_bd_d = 1'b0;
    else                d_bd_d = f_bd;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (advance) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_A;
      d_bd_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      d_bd_q <= d_bd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign d_bd      = d_bd_q;
  assign fetch_cnt = cnt_q;
  assign f_bd      = ctrl & ~eret;
  // AdEL is only flagged here; the PC keeps advancing until CP0 flushes.
  assign f_adel    = (pc_q[1:0] != 2'b00) || (pc_q < LO_A) || (pc_q > HI_A);

endmodule

// File: tb/tb_f_pc_unit.sv
// Bench for f_pc_unit: directed scenarios plus randomized traffic checked
// against an arithmetic next-PC model. A CNT_W=4 copy shares the inputs.
module tb_f_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  stall;
  logic        jump, jr, branch, cmp;
  logic [31:0] ra;
  logic [25:0] imm26;
  logic        req, eret;
  logic [31:0] epc;
  logic [31:0] pc, pc4;
  logic        f_bd, d_bd, f_adel;
  logic        f_bd4, d_bd4, f_adel4;
  logic [31:0] fetch_cnt;
  logic [3:0]  fetch_cnt4;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic        m_dbd;
  int unsigned m_cnt;

  f_pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .jr(jr),
    .branch(branch), .cmp(cmp), .ra(ra), .imm26(imm26), .req(req),
    .eret(eret), .epc(epc), .pc(pc), .f_bd(f_bd), .d_bd(d_bd),
    .f_adel(f_adel), .fetch_cnt(fetch_cnt)
  );

  f_pc_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .jr(jr),
    .branch(branch), .cmp(cmp), .ra(ra), .imm26(imm26), .req(req),
    .eret(eret), .epc(epc), .pc(pc4), .f_bd(f_bd4), .d_bd(d_bd4),
    .f_adel(f_adel4), .fetch_cnt(fetch_cnt4)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    reset = 0; stall = 2'b00; jump = 0; jr = 0; branch = 0; cmp = 0;
    ra = 32'h0; imm26 = 26'h0; req = 0; eret = 0; epc = 32'h0;
  endtask

  // Reference model: one clock edge applied to the architectural state.
  task automatic tick();
    logic [31:0] npc;
    logic        ndbd;
    logic        sa;
    sa = |stall;
    if (reset) begin
      npc = 32'h3000; ndbd = 0;
    end else begin
      if (req)                npc = 32'h4180;
      else if (sa)            npc = m_pc;
      else if (eret)          npc = epc;
      else if (jump)          npc = {m_pc[31:28], 28'h0} + {4'h0, imm26, 2'b00};
      else if (jr)            npc = ra;
      else if (branch && cmp) npc = 32'(longint'(m_pc) + longint'($signed(imm26[15:0])) * 4);
      else                    npc = m_pc + 32'd4;
      if (req)       ndbd = 0;
      else if (sa)   ndbd = m_dbd;
      else if (eret) ndbd = 0;
      else           ndbd = jump | jr | branch;
    end
    @(posedge clk);
    #1;
    if (reset) m_cnt = 0;
    else if (req || !sa) m_cnt = m_cnt + 1;
    m_pc  = npc;
    m_dbd = ndbd;
  endtask

  function automatic logic model_adel(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6ffc);
  endfunction

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pc !== 32'h3000) begin n_errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h3000); end
    n_checks++; if (d_bd !== 1'b0) begin n_errors++; $display("FAIL reset_dbd got %b want 0", d_bd); end
    n_checks++; if (fetch_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_cnt got %0d want 0", fetch_cnt); end
    n_checks++; if (fetch_cnt4 !== 4'd0) begin n_errors++; $display("FAIL reset_cnt4 got %0d want 0", fetch_cnt4); end
    n_checks++; if (f_adel !== 1'b0) begin n_errors++; $display("FAIL reset_adel got %b want 0", f_adel); end
  endtask

  task automatic test_free_run();
    logic [31:0] want;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick();
      want = 32'h3000 + 32'(i * 4);
      n_checks++; if (pc !== want) begin n_errors++; $display("FAIL free_pc%0d got %h want %h", i, pc, want); end
    end
    n_checks++; if (fetch_cnt !== 32'd3) begin n_errors++; $display("FAIL free_cnt got %0d want 3", fetch_cnt); end
    n_checks++; if (f_adel !== 1'b0) begin n_errors++; $display("FAIL free_adel got %b want 0", f_adel); end
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick();
    branch = 1; cmp = 1; imm26 = 26'h000fffe;
    #1;
    n_checks++; if (f_bd !== 1'b1) begin n_errors++; $display("FAIL branch_fbd got %b want 1", f_bd); end
    tick();
    clear_inputs();
    n_checks++; if (pc !== 32'h3000) begin n_errors++; $display("FAIL branch_pc got %h want %h", pc, 32'h3000); end
    n_checks++; if (d_bd !== 1'b1) begin n_errors++; $display("FAIL branch_dbd got %b want 1", d_bd); end
  endtask

  task automatic test_stall_jump();
    logic [31:0] pc0;
    int unsigned c0;
    pc0 = m_pc; c0 = m_cnt;
    stall = 2'b10; jump = 1; imm26 = 26'h1000;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (pc !== pc0) begin n_errors++; $display("FAIL stall_pc got %h want %h", pc, pc0); end
      n_checks++; if (fetch_cnt !== c0) begin n_errors++; $display("FAIL stall_cnt got %0d want %0d", fetch_cnt, c0); end
    end
    stall = 2'b00;
    tick();
    clear_inputs();
    n_checks++; if (pc !== 32'h4000) begin n_errors++; $display("FAIL jump_pc got %h want %h", pc, 32'h4000); end
    n_checks++; if (d_bd !== 1'b1) begin n_errors++; $display("FAIL jump_dbd got %b want 1", d_bd); end
  endtask

  task automatic test_req_stall();
    int unsigned c0;
    c0 = m_cnt;
    stall = 2'b01; req = 1; branch = 1; cmp = 1;
    tick();
    clear_inputs();
    n_checks++; if (pc !== 32'h4180) begin n_errors++; $display("FAIL req_pc got %h want %h", pc, 32'h4180); end
    n_checks++; if (d_bd !== 1'b0) begin n_errors++; $display("FAIL req_dbd got %b want 0", d_bd); end
    n_checks++; if (fetch_cnt !== c0 + 1) begin n_errors++; $display("FAIL req_cnt got %0d want %0d", fetch_cnt, c0 + 1); end
  endtask

  task automatic test_eret();
    logic [31:0] pc0;
    pc0 = m_pc;
    eret = 1; epc = 32'h3020; stall = 2'b01;
    tick();
    n_checks++; if (pc !== pc0) begin n_errors++; $display("FAIL eret_stall_pc got %h want %h", pc, pc0); end
    stall = 2'b00;
    #1;
    n_checks++; if (f_bd !== 1'b0) begin n_errors++; $display("FAIL eret_fbd got %b want 0", f_bd); end
    tick();
    clear_inputs();
    n_checks++; if (pc !== 32'h3020) begin n_errors++; $display("FAIL eret_pc got %h want %h", pc, 32'h3020); end
    n_checks++; if (d_bd !== 1'b0) begin n_errors++; $display("FAIL eret_dbd got %b want 0", d_bd); end
  endtask

  task automatic test_jr_adel();
    jr = 1; ra = 32'h3002;
    tick();
    n_checks++; if (pc !== 32'h3002) begin n_errors++; $display("FAIL jr_pc got %h want %h", pc, 32'h3002); end
    n_checks++; if (f_adel !== 1'b1) begin n_errors++; $display("FAIL adel_unaligned got %b want 1", f_adel); end
    ra = 32'h7000;
    tick();
    n_checks++; if (f_adel !== 1'b1) begin n_errors++; $display("FAIL adel_high got %b want 1", f_adel); end
    ra = 32'h6ffc;
    tick();
    clear_inputs();
    n_checks++; if (f_adel !== 1'b0) begin n_errors++; $display("FAIL adel_top_legal got %b want 0", f_adel); end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) tick();
    n_checks++; if (fetch_cnt4 !== 4'd0) begin n_errors++; $display("FAIL cnt4_wrap got %0d want 0", fetch_cnt4); end
    n_checks++; if (fetch_cnt !== 32'd16) begin n_errors++; $display("FAIL cnt_16 got %0d want 16", fetch_cnt); end
  endtask

  task automatic test_reset_mid();
    stall = 2'b11; req = 1; jump = 1; reset = 1;
    tick();
    clear_inputs();
    n_checks++; if (pc !== 32'h3000) begin n_errors++; $display("FAIL midreset_pc got %h want %h", pc, 32'h3000); end
    n_checks++; if (d_bd !== 1'b0) begin n_errors++; $display("FAIL midreset_dbd got %b want 0", d_bd); end
    n_checks++; if (fetch_cnt !== 32'd0) begin n_errors++; $display("FAIL midreset_cnt got %0d want 0", fetch_cnt); end
  endtask

  task automatic test_random();
    logic want_fbd;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 60) == 0);
      stall  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      req    = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 5))
        0: begin jump = 1; jr = 0; eret = 0; end
        1: begin jump = 0; jr = 1; eret = 0; end
        2: begin jump = 0; jr = 0; eret = 1; end
        default: begin jump = 0; jr = 0; eret = 0; end
      endcase
      branch = ($urandom_range(0, 3) == 0);
      cmp    = 1'($urandom_range(0, 1));
      imm26  = 26'($urandom);
      ra     = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 16383) * 4) / 2 * 2;
      epc    = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 4095) * 4);
      #1;
      want_fbd = (jump | jr | branch) & ~eret;
      n_checks++; if (f_bd !== want_fbd) begin n_errors++; $display("FAIL rnd_fbd cyc %0d got %b want %b", i, f_bd, want_fbd); end
      n_checks++; if (f_adel !== model_adel(m_pc)) begin n_errors++; $display("FAIL rnd_adel cyc %0d got %b want %b", i, f_adel, model_adel(m_pc)); end
      tick();
      n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, pc, m_pc); end
      n_checks++; if (d_bd !== m_dbd) begin n_errors++; $display("FAIL rnd_dbd cyc %0d got %b want %b", i, d_bd, m_dbd); end
      n_checks++; if (fetch_cnt !== m_cnt) begin n_errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", i, fetch_cnt, m_cnt); end
      n_checks++; if (fetch_cnt4 !== 4'(m_cnt)) begin n_errors++; $display("FAIL rnd_cnt4 cyc %0d got %0d want %0d", i, fetch_cnt4, 4'(m_cnt)); end
    end
    clear_inputs();
  endtask

  initial begin
    m_pc = 32'h3000; m_dbd = 0; m_cnt = 0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_free_run();
    test_branch();
    test_stall_jump();
    test_req_stall();
    test_eret();
    test_jr_adel();
    test_cnt_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
